// File: rtl/mux_scan_sel_pkg.sv
// ============================================================================
// Module   : mux_scan_pkg
// Brief    : Shared mode encodings and helpers for the mux_scan_sel stream mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_STATIC = 2'd0;
   localparam mode_t MODE_SCAN   = 2'd1;
   localparam mode_t MODE_ARB    = 2'd2;
   localparam mode_t MODE_HOLD   = 2'd3;

   function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned nch);
      return (sel >= nch) ? (nch - 1) : sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_sel_rr_next.sv
// ============================================================================
// Module   : mux_rr_next
// Brief    : Combinational round-robin finder: first valid channel after cur,
//            wrapping, with cur itself as the lowest-priority candidate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_next #(
   parameter  int NCH  = 4,
   localparam int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  ch_valid,
   input  logic [SELW-1:0] cur,
   output logic [SELW-1:0] next,
   output logic            any_valid
);

   // Scan from the farthest offset to the nearest so the nearest hit wins.
   always_comb begin
      logic [SELW:0] idx;
      next      = cur;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = NCH; k >= 1; k--) begin
         idx = {1'b0, cur} + (SELW+1)'(k);
         if (idx >= (SELW+1)'(NCH)) begin
            idx = idx - (SELW+1)'(NCH);
         end
         if (ch_valid[idx[SELW-1:0]]) begin
            next      = idx[SELW-1:0];
            any_valid = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux_scan_sel.sv
// ============================================================================
// Module   : mux_scan_sel
// Brief    : Registered N-channel stream mux with static, scan, round-robin
//            and hold selection. Define MUX_SCAN_SEL_PARITY_EN to add out_par.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_sel
   import mux_scan_pkg::*;
#(
   parameter  int NCH     = 4,
   parameter  int W       = 8,
   parameter  int DWELL_W = 8,
   localparam int SELW    = $clog2(NCH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  mode_t              mode,
   input  logic [SELW-1:0]    sel,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [NCH*W-1:0]   ch_data,
   input  logic [NCH-1:0]     ch_valid,
   output logic [NCH-1:0]     ch_ready,
   output logic [W-1:0]       out_data,
   output logic [SELW-1:0]    out_ch,
   output logic               out_valid,
`ifdef MUX_SCAN_SEL_PARITY_EN
   output logic               out_par,
`endif
   input  logic               out_ready
);

   logic [SELW-1:0]    cur_ch_q, cur_ch_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   mode_t              mode_q;
   logic [W-1:0]       out_data_q;
   logic [SELW-1:0]    out_ch_q;
   logic               out_valid_q;

   logic               go;
   logic               accept;
   logic [W-1:0]       cur_data;
   logic [SELW-1:0]    rr_next;
   logic               rr_any;

   assign cur_data = ch_data[cur_ch_q*W +: W];
   assign go       = en & (mode != MODE_HOLD) & (~out_valid_q | out_ready);
   assign accept   = go & ch_valid[cur_ch_q] & ~rst;

   always_comb begin
      ch_ready = '0;
      if (!rst) begin
         ch_ready[cur_ch_q] = go;
      end
   end

   mux_rr_next #(
      .NCH (NCH)
   ) u_rr_next (
      .ch_valid  (ch_valid),
      .cur       (cur_ch_q),
      .next      (rr_next),
      .any_valid (rr_any)
   );

   // A mode switch only restarts the dwell timer; the channel pointer is kept.
   always_comb begin
      cur_ch_d    = cur_ch_q;
      dwell_cnt_d = dwell_cnt_q;
      if (mode != mode_q) begin
         dwell_cnt_d = '0;
      end else if (en) begin
         case (mode)
            MODE_STATIC: cur_ch_d = SELW'(clamp_sel(32'(sel), NCH));
            MODE_SCAN: begin
               if (dwell_cnt_q == dwell) begin
                  cur_ch_d    = (cur_ch_q == SELW'(NCH-1)) ? '0 : cur_ch_q + SELW'(1);
                  dwell_cnt_d = '0;
               end else begin
                  dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
               end
            end
            MODE_ARB: begin
               if ((accept | ~ch_valid[cur_ch_q]) & rr_any) begin
                  cur_ch_d = rr_next;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_ch_q    <= '0;
         dwell_cnt_q <= '0;
         mode_q      <= MODE_STATIC;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cur_ch_q    <= cur_ch_d;
         dwell_cnt_q <= dwell_cnt_d;
         mode_q      <= mode;
         if (accept) begin
            out_data_q  <= cur_data;
            out_ch_q    <= cur_ch_q;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

`ifdef MUX_SCAN_SEL_PARITY_EN
   logic out_par_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_par_q <= 1'b0;
      end else if (accept) begin
         out_par_q <= ^cur_data;
      end
   end

   assign out_par = out_par_q;
`endif

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sel.sv
// ============================================================================
// Module   : tb_mux_scan_sel
// Brief    : Scoreboard-based bench for mux_scan_sel (NCH=4, W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_sel;
   import mux_scan_pkg::*;

   localparam int NCH     = 4;
   localparam int W       = 8;
   localparam int DWELL_W = 8;
   localparam int SELW    = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   mode_t              mode;
   logic [SELW-1:0]    sel;
   logic [DWELL_W-1:0] dwell;
   logic [NCH*W-1:0]   ch_data;
   logic [NCH-1:0]     ch_valid;
   logic [NCH-1:0]     ch_ready;
   logic [W-1:0]       out_data;
   logic [SELW-1:0]    out_ch;
   logic               out_valid;
   logic               out_ready;
`ifdef MUX_SCAN_SEL_PARITY_EN
   logic               out_par;
`endif

   typedef struct packed {
      logic [SELW-1:0] ch;
      logic [W-1:0]    data;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [NCH*W-1:0] BASE_DATA = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

   always #5 clk = ~clk;

   mux_scan_sel #(
      .NCH     (NCH),
      .W       (W),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .sel       (sel),
      .dwell     (dwell),
      .ch_data   (ch_data),
      .ch_valid  (ch_valid),
      .ch_ready  (ch_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
`ifdef MUX_SCAN_SEL_PARITY_EN
      .out_par   (out_par),
`endif
      .out_ready (out_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input int ch, input logic [W-1:0] d);
      exp_t r;
      r.ch   = SELW'(ch);
      r.data = d;
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1; en = 1'b1; mode = MODE_STATIC; sel = '0; dwell = '0;
      ch_data = BASE_DATA; ch_valid = '1; out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++;
      if (ch_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", ch_ready); end
      checks++;
      if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", out_ch); end
      rst = 1'b0;
      sb.push_back(mk(0, 8'hA0));
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL reset_first_valid: got %b expected 1", out_valid);
      end else begin
         e = sb.pop_front();
         if (out_ch !== e.ch || out_data !== e.data) begin
            errors++;
            $display("FAIL reset_first_out: got ch=%0d data=%h expected ch=%0d data=%h", out_ch, out_data, e.ch, e.data);
         end
      end
      ch_valid = '0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         errors++; $display("FAIL reset_drain: got valid=%b pending=%0d expected 0/0", out_valid, sb.size());
      end
   endtask

   task automatic test_static_backpressure();
      logic [W-1:0] src [3] = '{8'h11, 8'h22, 8'h33};
      int   k    = 0;
      int   pops = 0;
      logic hs;
      exp_t e;
      mode = MODE_STATIC; sel = 2'd2; ch_valid = '0; out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         out_ready = !(c >= 3 && c <= 5);
         ch_valid  = (k < 3) ? 4'b0100 : 4'b0000;
         ch_data[2*W +: W] = (k < 3) ? src[k] : 8'h00;
         @(negedge clk);
         hs = ch_valid[2] & ch_ready[2];
         if (out_valid && !out_ready) begin
            checks++;
            if (sb.size() == 0 || out_data !== sb[0].data) begin
               errors++; $display("FAIL static_stall_hold: got data=%h expected %h", out_data, (sb.size() != 0) ? sb[0].data : 8'h00);
            end
         end
         if (out_valid && out_ready) begin
            checks++; pops++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL static_out: got ch=%0d data=%h expected no word", out_ch, out_data);
            end else begin
               e = sb.pop_front();
               if (out_ch !== e.ch || out_data !== e.data) begin
                  errors++;
                  $display("FAIL static_out: got ch=%0d data=%h expected ch=%0d data=%h", out_ch, out_data, e.ch, e.data);
               end
            end
         end
         if (hs) begin
            sb.push_back(mk(2, src[k]));
            k++;
         end
         tick();
      end
      checks++;
      if (pops != 3 || sb.size() != 0) begin
         errors++; $display("FAIL static_count: got pops=%0d pending=%0d expected 3/0", pops, sb.size());
      end
      ch_data = BASE_DATA;
   endtask

   task automatic test_scan();
      int   seq_a [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
      int   pops = 0;
      exp_t e;
      en = 1'b0; mode = MODE_SCAN; dwell = 8'd2; ch_valid = '1; ch_data = BASE_DATA; out_ready = 1'b1;
      do_reset();
      tick();
      foreach (seq_a[i]) sb.push_back(mk(seq_a[i], 8'hA0 + 8'(seq_a[i])));
      en = 1'b1;
      for (int c = 0; c < 24; c++) begin
         case (c)
            13: begin en = 1'b0; mode = MODE_HOLD; end
            14: begin mode = MODE_SCAN; dwell = 8'd0; end
            15: begin
               en = 1'b1;
               for (int i = 0; i < 8; i++) sb.push_back(mk(i % 4, 8'hA0 + 8'(i % 4)));
            end
            23: en = 1'b0;
            default: ;
         endcase
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++; pops++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL scan_out: got ch=%0d data=%h expected no word", out_ch, out_data);
            end else begin
               e = sb.pop_front();
               if (out_ch !== e.ch || out_data !== e.data) begin
                  errors++;
                  $display("FAIL scan_out: got ch=%0d data=%h expected ch=%0d data=%h", out_ch, out_data, e.ch, e.data);
               end
            end
         end
         tick();
      end
      checks++;
      if (pops != 21 || sb.size() != 0) begin
         errors++; $display("FAIL scan_count: got pops=%0d pending=%0d expected 21/0", pops, sb.size());
      end
   endtask

   task automatic test_arb();
      int   seq [10] = '{1, 3, 1, 3, 1, 3, 1, 1, 1, 1};
      int   pops = 0;
      exp_t e;
      en = 1'b0; ch_valid = '0; ch_data = BASE_DATA; out_ready = 1'b1; mode = MODE_STATIC;
      do_reset();
      foreach (seq[i]) sb.push_back(mk(seq[i], 8'hA0 + 8'(seq[i])));
      en = 1'b1; mode = MODE_ARB;
      for (int c = 0; c < 13; c++) begin
         ch_valid = (c < 8) ? 4'b1010 : ((c < 12) ? 4'b0010 : 4'b0000);
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++; pops++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL arb_out: got ch=%0d data=%h expected no word", out_ch, out_data);
            end else begin
               e = sb.pop_front();
               if (out_ch !== e.ch || out_data !== e.data) begin
                  errors++;
                  $display("FAIL arb_out: got ch=%0d data=%h expected ch=%0d data=%h", out_ch, out_data, e.ch, e.data);
               end
            end
         end
         tick();
      end
      checks++;
      if (pops != 10 || sb.size() != 0) begin
         errors++; $display("FAIL arb_count: got pops=%0d pending=%0d expected 10/0", pops, sb.size());
      end
   endtask

   task automatic test_hold();
      int   pops = 0;
      exp_t e;
      en = 1'b1; mode = MODE_SCAN; dwell = 8'd5; ch_valid = '0; ch_data = BASE_DATA; out_ready = 1'b1;
      do_reset();
      for (int c = 0; c < 17; c++) begin
         case (c)
            3: begin ch_valid = 4'b0001; sb.push_back(mk(0, 8'hA0)); end
            4: begin mode = MODE_HOLD; ch_valid = 4'b1111; end
            8: begin
               mode = MODE_SCAN;
               for (int i = 0; i < 7; i++) sb.push_back(mk(0, 8'hA0));
               sb.push_back(mk(1, 8'hA1));
            end
            16: en = 1'b0;
            default: ;
         endcase
         @(negedge clk);
         if (c >= 4 && c <= 7) begin
            checks++;
            if (ch_ready !== 4'b0000) begin
               errors++; $display("FAIL hold_ready: cycle %0d got %b expected 0000", c, ch_ready);
            end
         end
         if (c >= 5 && c <= 7) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++; $display("FAIL hold_drained: cycle %0d got valid=%b expected 0", c, out_valid);
            end
         end
         if (out_valid && out_ready) begin
            checks++; pops++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL hold_out: got ch=%0d data=%h expected no word", out_ch, out_data);
            end else begin
               e = sb.pop_front();
               if (out_ch !== e.ch || out_data !== e.data) begin
                  errors++;
                  $display("FAIL hold_out: got ch=%0d data=%h expected ch=%0d data=%h", out_ch, out_data, e.ch, e.data);
               end
            end
         end
         tick();
      end
      checks++;
      if (pops != 9 || sb.size() != 0) begin
         errors++; $display("FAIL hold_count: got pops=%0d pending=%0d expected 9/0", pops, sb.size());
      end
   endtask

`ifdef MUX_SCAN_SEL_PARITY_EN
   task automatic test_parity();
      logic [W-1:0] pdat [3] = '{8'h07, 8'h03, 8'h07};
      logic         pexp [3] = '{1'b1, 1'b0, 1'b1};
      en = 1'b1; mode = MODE_STATIC; sel = 2'd0; ch_data = BASE_DATA; ch_valid = '0; out_ready = 1'b1;
      do_reset();
      ch_valid = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         ch_data[0 +: W] = pdat[i];
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_par !== pexp[i] || out_data !== pdat[i]) begin
            errors++;
            $display("FAIL parity_word%0d: got valid=%b par=%b data=%h expected 1/%b/%h", i, out_valid, out_par, out_data, pexp[i], pdat[i]);
         end
      end
      rst = 1'b1;
      tick();
      checks++;
      if (out_par !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL parity_reset: got par=%b valid=%b expected 0/0", out_par, out_valid);
      end
      rst = 1'b0; ch_valid = '0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_static_backpressure();
      test_scan();
      test_arb();
      test_hold();
`ifdef MUX_SCAN_SEL_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
